alu_rr_arbiter: RTL and testbench

ALU_RR_ARBITER -- requirements
Module: alu_rr_arbiter

---
 rtl/alu_rr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_alu_rr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: two requesters share one small ALU through a round-robin
// arbiter. A grant latches the winner's opcode and operands, the next cycle
// computes and registers the result, and the cycle after that strobes it.
// Optional build macro: ALU_RR_ARBITER_CARRY_EN adds the 'flag' output
// (carry for ADD, borrow for SUB, 0 for AND/OR), registered alongside 'out'.
module alu_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0,
   input  logic         req1,
   input  logic [1:0]   op0,
   input  logic [1:0]   op1,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] b0,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] b1,
   output logic         gnt0,
   output logic         gnt1,
   output logic [N-1:0] out,
   output logic         out_valid,
   output logic         out_id,
   output logic         busy
`ifdef ALU_RR_ARBITER_CARRY_EN
   ,
   output logic         flag
`endif
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_AND = 2'b01;
   localparam logic [1:0] OP_SUB = 2'b10;
   localparam logic [1:0] OP_OR  = 2'b11;

   state_t       state_q, state_d;
   logic         last_q, last_d;     // requester served most recently
   logic [1:0]   op_q, op_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic         id_q, id_d;         // owner of the operation in flight
   logic [N-1:0] out_q, out_d;
   logic         out_id_q, out_id_d;
   logic         win;
   logic [N-1:0] res;
`ifdef ALU_RR_ARBITER_CARRY_EN
   logic         cf;
   logic         flag_q, flag_d;
`endif

   // Round-robin pick: a lone requester wins, a tie goes to the one not served last
   always_comb begin
      win = req1;
      if (req0 && req1) win = ~last_q;
   end

   // ALU works only on the latched operands so input changes after the grant are ignored
   always_comb begin
      res = '0;
      case (op_q)
         OP_ADD:  res = a_q + b_q;
         OP_AND:  res = a_q & b_q;
         OP_SUB:  res = a_q - b_q;
         OP_OR:   res = a_q | b_q;
         default: res = '0;
      endcase
   end

`ifdef ALU_RR_ARBITER_CARRY_EN
   // Carry out of ADD shows up as a wrapped sum smaller than an addend; SUB borrows when a<b
   always_comb begin
      cf = 1'b0;
      case (op_q)
         OP_ADD:  cf = (res < a_q);
         OP_SUB:  cf = (a_q < b_q);
         default: cf = 1'b0;
      endcase
   end
`endif

   // Next-state, grant and datapath-load decisions
   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      id_d     = id_q;
      out_d    = out_q;
      out_id_d = out_id_q;
`ifdef ALU_RR_ARBITER_CARRY_EN
      flag_d   = flag_q;
`endif
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      case (state_q)
         IDLE: begin
            // Gated by reset so a requester never sees a grant that is then dropped
            if (!rst && (req0 || req1)) begin
               gnt0    = ~win;
               gnt1    = win;
               last_d  = win;
               id_d    = win;
               op_d    = win ? op1 : op0;
               a_d     = win ? a1 : a0;
               b_d     = win ? b1 : b0;
               state_d = EXEC;
            end
         end
         EXEC: begin
            out_d    = res;
            out_id_d = id_q;
`ifdef ALU_RR_ARBITER_CARRY_EN
            flag_d   = cf;
`endif
            state_d  = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset wins over everything and aborts any operation
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;   // so requester 0 wins the first tie
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         id_q     <= 1'b0;
         out_q    <= '0;
         out_id_q <= 1'b0;
`ifdef ALU_RR_ARBITER_CARRY_EN
         flag_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         id_q     <= id_d;
         out_q    <= out_d;
         out_id_q <= out_id_d;
`ifdef ALU_RR_ARBITER_CARRY_EN
         flag_q   <= flag_d;
`endif
      end
   end

   assign out       = out_q;
   assign out_id    = out_id_q;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
`ifdef ALU_RR_ARBITER_CARRY_EN
   assign flag      = flag_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: the driver predicts grants from the
// round-robin rule and pushes expected results; a monitor pops and compares
// whenever out_valid is seen, and checks hold/reset values otherwise.
module tb_alu_rr_arbiter;
   localparam int N   = 4;
   localparam int MOD = 1 << N;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0 = 1'b0, req1 = 1'b0;
   logic [1:0]   op0 = '0, op1 = '0;
   logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic         gnt0, gnt1, out_valid, out_id, busy;
   logic [N-1:0] out;
`ifdef ALU_RR_ARBITER_CARRY_EN
   logic         flag;
`endif

   typedef struct {
      int     id;
      int     res;
      int     flg;
      longint due;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   m_wait = 0;   // cycles the model still considers the ALU occupied
   int   m_last = 1;   // model's last-served requester
   int   held_out = 0;
   int   held_id  = 0;

   alu_rr_arbiter #(.N(N)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1),
      .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .out(out), .out_valid(out_valid),
      .out_id(out_id), .busy(busy)
`ifdef ALU_RR_ARBITER_CARRY_EN
      , .flag(flag)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference ALU from the opcode table, modulo 2^N
   function automatic exp_t model(input int id, input int op, input int a, input int b);
      exp_t e;
      e.id  = id;
      e.flg = 0;
      e.due = 0;
      case (op)
         0: begin e.res = (a + b) % MOD; e.flg = (a + b >= MOD) ? 1 : 0; end
         1: e.res = a & b;
         2: begin e.res = (a - b + MOD) % MOD; e.flg = (a < b) ? 1 : 0; end
         default: e.res = a | b;
      endcase
      return e;
   endfunction

   // One clock cycle: inputs already set just after a falling edge
   task automatic cyc(output bit g0, output bit g1);
      int   w;
      exp_t e;
      #1;
      g0 = 0; g1 = 0; w = -1;
      if (!rst) begin
         chk("busy", busy, (m_wait > 0) ? 1 : 0);
         if (m_wait == 0 && (req0 || req1))
            w = (req0 && req1) ? 1 - m_last : (req1 ? 1 : 0);
      end
      chk("gnt0", gnt0, (w == 0) ? 1 : 0);
      chk("gnt1", gnt1, (w == 1) ? 1 : 0);
      if (rst) begin
         m_wait = 0; m_last = 1; sbq.delete();
      end else if (w >= 0) begin
         g0 = (w == 0); g1 = (w == 1);
         m_last = w; m_wait = 2;
         e = (w == 0) ? model(0, int'(op0), int'(a0), int'(b0))
                      : model(1, int'(op1), int'(a1), int'(b1));
         e.due = $time + 16;   // falls in the monitor window two cycles later
         sbq.push_back(e);
      end else if (m_wait > 0) begin
         m_wait--;
      end
      @(negedge clk);
   endtask

   // Monitor: samples shortly after each rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk); #2;
         if (rst) begin
            chk("rst_out", out, 0);
            chk("rst_id", out_id, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_gnt", {gnt1, gnt0}, 0);
`ifdef ALU_RR_ARBITER_CARRY_EN
            chk("rst_flag", flag, 0);
`endif
            held_out = 0; held_id = 0;
         end else if (out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               checks++; errors++;
               $display("FAIL unexpected_valid: got out=%0h id=%0d expected no result at %0t", out, out_id, $time);
            end else begin
               e = sbq.pop_front();
               chk("out", out, e.res);
               chk("out_id", out_id, e.id);
               chk("latency", $time, e.due);
`ifdef ALU_RR_ARBITER_CARRY_EN
               chk("flag", flag, e.flg);
`endif
               held_out = e.res; held_id = e.id;
            end
         end else begin
            chk("hold_out", out, held_out);
            chk("hold_id", out_id, held_id);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      bit g0, g1, p0, p1;
      int n0, n1, guard, alt_err;
      @(negedge clk);
      rst = 1'b1; cyc(g0, g1); cyc(g0, g1);
      rst = 1'b0; cyc(g0, g1);

      // 3 - 5 wraps to 1110
      req0 = 1; op0 = 2'b10; a0 = 4'b0011; b0 = 4'b0101; cyc(g0, g1);
      chk("dir_gnt0", g0, 1);
      req0 = 0; cyc(g0, g1); cyc(g0, g1); cyc(g0, g1);

      // F + 1 wraps to 0 with carry
      req1 = 1; op1 = 2'b00; a1 = 4'hF; b1 = 4'h1; cyc(g0, g1);
      req1 = 0; cyc(g0, g1); cyc(g0, g1); cyc(g0, g1);

      // operands scrambled right after the grant must not leak into the result
      req0 = 1; op0 = 2'b00; a0 = 4'h1; b0 = 4'h2; cyc(g0, g1);
      req0 = 0; op0 = 2'b11; a0 = 4'hF; b0 = 4'hF; cyc(g0, g1); cyc(g0, g1); cyc(g0, g1);

      // both held continuously after reset: strict 0,1,0,1 alternation
      rst = 1; cyc(g0, g1); rst = 0;
      req0 = 1; req1 = 1; alt_err = 0; n0 = 0;
      for (int i = 0; i < 12; i++) begin
         op0 = 2'($urandom_range(0, 3)); a0 = N'($urandom); b0 = N'($urandom);
         op1 = 2'($urandom_range(0, 3)); a1 = N'($urandom); b1 = N'($urandom);
         cyc(g0, g1);
         if (g0 || g1) begin
            if (g1 != n0[0]) alt_err++;
            n0++;
         end
      end
      chk("alt_count", n0, 4);
      chk("alt_order", alt_err, 0);
      req0 = 0; req1 = 0; cyc(g0, g1); cyc(g0, g1); cyc(g0, g1);

      // reset during EXEC aborts the result and restores the tie pointer
      req0 = 1; op0 = 2'b01; a0 = 4'hC; b0 = 4'hA; cyc(g0, g1);
      req0 = 0; rst = 1; cyc(g0, g1);
      rst = 0; cyc(g0, g1); cyc(g0, g1);
      req0 = 1; req1 = 1; cyc(g0, g1);
      chk("tie_after_rst", {g1, g0}, 2'b01);
      req0 = 0; req1 = 0; cyc(g0, g1); cyc(g0, g1); cyc(g0, g1);

      // random traffic: 100 operations per requester, requests held until granted
      p0 = 0; p1 = 0; n0 = 0; n1 = 0; guard = 0;
      while ((n0 < 100 || n1 < 100) && guard < 6000) begin
         if (!p0) begin
            op0 = 2'($urandom_range(0, 3)); a0 = N'($urandom); b0 = N'($urandom);
            if (n0 < 100 && $urandom_range(0, 2) != 0) p0 = 1;
         end
         if (!p1) begin
            op1 = 2'($urandom_range(0, 3)); a1 = N'($urandom); b1 = N'($urandom);
            if (n1 < 100 && $urandom_range(0, 2) != 0) p1 = 1;
         end
         req0 = p0; req1 = p1;
         cyc(g0, g1);
         if (g0) begin p0 = 0; n0++; end
         if (g1) begin p1 = 0; n1++; end
         guard++;
      end
      chk("rand_ops0", n0, 100);
      chk("rand_ops1", n1, 100);
      req0 = 0; req1 = 0;
      for (int i = 0; i < 4; i++) cyc(g0, g1);
      chk("drain", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
